// File: rtl/gf_pkg.sv
// Shared types and helpers for the digit-serial carry-less multiplier.
// Optional modular reduction is enabled by defining GF_MULT_REDUCE_EN.
package gf_pkg;

  typedef enum logic [1:0] {IDLE, RUN, REDUCE, DONE} gf_mult_state_t;

  // Fixed upper bounds let one function serve every parameterisation; callers size-cast.
  localparam int unsigned MaxWidth = 64;
  localparam int unsigned MaxDigit = 64;
  localparam int unsigned MaxProd  = MaxWidth + MaxDigit - 1;

  function automatic logic [MaxProd-1:0] clmul_digit(input logic [MaxWidth-1:0] a,
                                                     input logic [MaxDigit-1:0] d);
    logic [MaxProd-1:0] res;
    res = '0;
    for (int unsigned j = 0; j < MaxDigit; j++) begin
      if (d[j]) res = res ^ (MaxProd'(a) << j);
    end
    return res;
  endfunction

  function automatic bit gf_cfg_ok(input int unsigned w, input int unsigned d);
    return (w >= 2) && (w <= MaxWidth) && (d >= 1) && (d <= w) && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/gf_digit_mac.sv
// One W x D carry-less partial product, shifted to digit position k and XORed into the
// accumulator. Purely combinational; reused on every RUN cycle.
module gf_digit_mac
  import gf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DIGIT_WIDTH = 4,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic [2*DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DIGIT_WIDTH-1:0]  digit_i,
  input  logic [CNT_WIDTH-1:0]    k_i,
  output logic [2*DATA_WIDTH-1:0] acc_o
);

  localparam int unsigned ProdW = DATA_WIDTH + DIGIT_WIDTH - 1;

  logic [ProdW-1:0]        pp;
  logic [2*DATA_WIDTH-1:0] pp_ext;

  always_comb begin
    pp     = ProdW'(clmul_digit(MaxWidth'(a_i), MaxDigit'(digit_i)));
    pp_ext = (2*DATA_WIDTH)'(pp);
    acc_o  = acc_i ^ (pp_ext << (32'(k_i) * DIGIT_WIDTH));
  end

endmodule

// File: rtl/gf_mult_digit_serial.sv
// Digit-serial GF(2)[x] multiplier with valid/ready handshakes on both sides.
// Define GF_MULT_REDUCE_EN to add the poly port and reduction into GF(2^DATA_WIDTH).
module gf_mult_digit_serial
  import gf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DIGIT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
`ifdef GF_MULT_REDUCE_EN
  input  logic [DATA_WIDTH-1:0]   poly,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out,
  output logic                    busy
);

  localparam int unsigned N    = DATA_WIDTH / DIGIT_WIDTH;
  localparam int unsigned CntW = $clog2(N) + 1;
  localparam logic [CntW-1:0] KLast = CntW'(N - 1);

  if (!gf_cfg_ok(DATA_WIDTH, DIGIT_WIDTH)) begin : g_cfg_err
    $error("gf_mult_digit_serial: DIGIT_WIDTH must divide DATA_WIDTH (W >= 2, W <= 64)");
  end

  gf_mult_state_t          state_q, state_d;
  logic [CntW-1:0]         k_q, k_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
  logic [2*DATA_WIDTH-1:0] mac_acc;
  logic [DIGIT_WIDTH-1:0]  digit;
  logic                    accept;

  assign digit = DIGIT_WIDTH'(b_q >> (32'(k_q) * DIGIT_WIDTH));

  gf_digit_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DIGIT_WIDTH (DIGIT_WIDTH),
    .CNT_WIDTH   (CntW)
  ) u_mac (
    .acc_i   (acc_q),
    .a_i     (a_q),
    .digit_i (digit),
    .k_i     (k_q),
    .acc_o   (mac_acc)
  );

`ifdef GF_MULT_REDUCE_EN
  logic [DATA_WIDTH-1:0]   poly_q, poly_d;
  logic [2*DATA_WIDTH-1:0] red_acc;
  logic [2*DATA_WIDTH-1:0] modulus;
  int unsigned             red_top;
  int unsigned             red_idx;

  // Pass k folds the window [2W-1-k*D -: D]; every bit there is >= W, and lower bits of the
  // same window may be set by the higher folds, hence the high-to-low order.
  always_comb begin
    modulus = (2*DATA_WIDTH)'({1'b1, poly_q});
    red_acc = acc_q;
    red_top = 2 * DATA_WIDTH - 1 - 32'(k_q) * DIGIT_WIDTH;
    red_idx = 0;
    for (int unsigned t = 0; t < DIGIT_WIDTH; t++) begin
      red_idx = red_top - t;
      if (red_acc[red_idx]) red_acc = red_acc ^ (modulus << (red_idx - DATA_WIDTH));
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
`ifdef GF_MULT_REDUCE_EN
    poly_d  = poly_q;
`endif
    in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    accept   = in_valid && in_ready;

    unique case (state_q)
      IDLE: ;
      RUN: begin
        acc_d = mac_acc;
        if (k_q == KLast) begin
          k_d = '0;
`ifdef GF_MULT_REDUCE_EN
          state_d = REDUCE;
`else
          state_d = DONE;
`endif
        end else begin
          k_d = k_q + CntW'(1);
        end
      end
`ifdef GF_MULT_REDUCE_EN
      REDUCE: begin
        acc_d = red_acc;
        if (k_q == KLast) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + CntW'(1);
        end
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Accept only happens in IDLE or DONE, so it overrides whatever the case chose.
    if (accept) begin
      a_d     = a;
      b_d     = b;
      acc_d   = '0;
      k_d     = '0;
      state_d = RUN;
`ifdef GF_MULT_REDUCE_EN
      poly_d  = poly;
`endif
    end

    out_valid = (state_q == DONE);
    out       = out_valid ? acc_q : '0;
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
`ifdef GF_MULT_REDUCE_EN
      poly_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
`ifdef GF_MULT_REDUCE_EN
      poly_q  <= poly_d;
`endif
    end
  end

endmodule

// File: tb/tb_gf_mult_digit_serial.sv
// Directed bench for gf_mult_digit_serial: an 8x2 instance for handshake/latency/reset cases
// and a 32x4 instance for the wide identity case. Follows GF_MULT_REDUCE_EN if defined.
module tb_gf_mult_digit_serial;

  localparam int unsigned N8  = 4;
  localparam int unsigned N32 = 8;
`ifdef GF_MULT_REDUCE_EN
  localparam int unsigned Lat8  = 2 * N8;
  localparam int unsigned Lat32 = 2 * N32;
  localparam logic [15:0] ExpFf = 16'h0013;
  localparam logic [15:0] Exp80 = 16'h009A;
`else
  localparam int unsigned Lat8  = N8;
  localparam int unsigned Lat32 = N32;
  localparam logic [15:0] ExpFf = 16'h5555;
  localparam logic [15:0] Exp80 = 16'h4000;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;
  logic        in_valid32, in_ready32, out_valid32, out_ready32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] out32;
`ifdef GF_MULT_REDUCE_EN
  logic [7:0]  poly8;
  logic [31:0] poly32;
`endif

  int checks = 0;
  int errors = 0;

  gf_mult_digit_serial #(
    .DATA_WIDTH  (8),
    .DIGIT_WIDTH (2)
  ) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
`ifdef GF_MULT_REDUCE_EN
    .poly      (poly8),
`endif
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out       (out8),
    .busy      (busy8)
  );

  gf_mult_digit_serial #(
    .DATA_WIDTH  (32),
    .DIGIT_WIDTH (4)
  ) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .a         (a32),
    .b         (b32),
`ifdef GF_MULT_REDUCE_EN
    .poly      (poly32),
`endif
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .out       (out32),
    .busy      (busy32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE with out_ready=1, checks exact latency, value and one-cycle valid.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp,
                     input string tag);
    a8 = av;
    b8 = bv;
    in_valid8  = 1'b1;
    out_ready8 = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(in_ready8), 64'd1);
    tick();
    in_valid8 = 1'b0;
    for (int i = 1; i <= int'(Lat8); i++) begin
      tick();
      chk($sformatf("%s_vld%0d", tag, i), 64'(out_valid8), 64'(i == int'(Lat8)));
    end
    chk({tag, "_out"}, 64'(out8), 64'(exp));
    tick();
    chk({tag, "_drop"}, 64'(out_valid8), 64'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid8   = 1'b1;
    out_ready8  = 1'b0;
    a8          = 8'h00;
    b8          = 8'h00;
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    a32         = 32'h0;
    b32         = 32'h0;
`ifdef GF_MULT_REDUCE_EN
    poly8  = 8'h1B;
    poly32 = 32'h0000_008D;
`endif

    // 1. Reset held for three edges with in_valid high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_vld%0d", i), 64'(out_valid8), 64'd0);
      chk($sformatf("rst_out%0d", i), 64'(out8), 64'd0);
      chk($sformatf("rst_busy%0d", i), 64'(busy8), 64'd0);
      chk($sformatf("rst_rdy%0d", i), 64'(in_ready8), 64'd0);
    end
    chk("rst_busy32", 64'(busy32), 64'd0);
    in_valid8 = 1'b0;
    rst_n     = 1'b1;
    #1;
    chk("rel_rdy", 64'(in_ready8), 64'd1);
    chk("rel_busy", 64'(busy8), 64'd0);

    // 2. Small product, exact latency
    op8(8'h03, 8'h03, 16'h0005, "t2");

    // 3. Full-ones square, result held under backpressure
    a8 = 8'hFF;
    b8 = 8'hFF;
    in_valid8  = 1'b1;
    out_ready8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    chk("t3_busy", 64'(busy8), 64'd1);
    for (int i = 1; i <= int'(Lat8); i++) tick();
    chk("t3_vld", 64'(out_valid8), 64'd1);
    chk("t3_out", 64'(out8), 64'(ExpFf));
    a8 = 8'h01;
    b8 = 8'h01;
    in_valid8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t3_hold_out%0d", i), 64'(out8), 64'(ExpFf));
      chk($sformatf("t3_hold_rdy%0d", i), 64'(in_ready8), 64'd0);
    end
    chk("t3_hold_vld", 64'(out_valid8), 64'd1);

    // 4. Back-to-back: new operands accepted on the edge the result is taken
    a8 = 8'h80;
    b8 = 8'h80;
    out_ready8 = 1'b1;
    #1;
    chk("t4_rdy", 64'(in_ready8), 64'd1);
    tick();
    in_valid8 = 1'b0;
    chk("t4_vld_drop", 64'(out_valid8), 64'd0);
    chk("t4_busy", 64'(busy8), 64'd1);
    for (int i = 1; i <= int'(Lat8); i++) begin
      tick();
      chk($sformatf("t4_vld%0d", i), 64'(out_valid8), 64'(i == int'(Lat8)));
    end
    chk("t4_out", 64'(out8), 64'(Exp80));
    tick();
    chk("t4_idle", 64'(busy8), 64'd0);

    // 5. Reset on the second RUN edge aborts the operation
    a8 = 8'hA5;
    b8 = 8'h3C;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("t5_busy", 64'(busy8), 64'd0);
    chk("t5_vld", 64'(out_valid8), 64'd0);
    chk("t5_out", 64'(out8), 64'd0);
    rst_n = 1'b1;
    op8(8'h02, 8'h02, 16'h0004, "t5_next");

`ifdef GF_MULT_REDUCE_EN
    // 6a. AES field product
    op8(8'h57, 8'h83, 16'h00C1, "t6_aes");
`endif

    // 6b. Wide instance, multiply by one
    a32 = 32'h0000_0001;
    b32 = 32'hDEAD_BEEF;
    in_valid32 = 1'b1;
    tick();
    in_valid32 = 1'b0;
    for (int i = 1; i < int'(Lat32); i++) tick();
    chk("t6_w32_early", 64'(out_valid32), 64'd0);
    tick();
    chk("t6_w32_vld", 64'(out_valid32), 64'd1);
    chk("t6_w32_out", out32, 64'h0000_0000_DEAD_BEEF);
    tick();
    chk("t6_w32_drop", 64'(out_valid32), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
